mgmt_sram_ctrl: RTL and testbench

Parametrised successor to the single-bank management DFFRAM hookup. It splits the management SRAM into NUM_BANKS independent banks and arbitrates per bank between the CPU read/write port and the housekeeping read-only port, using aging-based anti-starvation. Requests to different banks are served concurrently. It sits between mgmt_core's dff interface and the RAM macros/behavioural banks, all on core_clk.

---
 rtl/mgmt_sram_pkg.sv | 36 +++
 rtl/mgmt_sram_bank.sv | 66 ++++++
 rtl/mgmt_sram_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mgmt_sram_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_sram_pkg.sv
// mgmt_sram_pkg: shared constants, grant encoding and helper functions for
// the banked management SRAM controller (mgmt_sram_ctrl, mgmt_sram_bank).
package mgmt_sram_pkg;

    localparam int unsigned DW        = 32;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned WAIT_W    = 4;

    // Per-bank arbitration result.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_HK   = 2'd2
    } gnt_e;

    // Width of the bank-select field inside a word address (0 for one bank).
    function automatic int unsigned bank_sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Width of a bank-index signal; never zero so it can always be declared.
    function automatic int unsigned bank_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Even parity, one bit per byte lane.
    function automatic logic [NUM_LANES-1:0] lane_parity(input logic [DW-1:0] d);
        logic [NUM_LANES-1:0] p;
        for (int l = 0; l < NUM_LANES; l++) begin
            p[l] = ^d[l*LANE_W +: LANE_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/mgmt_sram_bank.sv
// mgmt_sram_bank: one single-port 32-bit SRAM bank with byte-lane writes.
// Writes are synchronous; the read port is combinational so the controller
// can register the granted bank's word directly into its output registers.
// Build option MGMT_SRAM_PARITY_EN adds one even-parity bit per byte lane.
// Ports:
//   clk   - clock
//   en    - bank selected this cycle
//   we    - byte write enables (0 = read)
//   addr  - word address within the bank
//   din   - write data
//   dout  - read data at addr
//   pout  - stored parity bits at addr (parity build only)
module mgmt_sram_bank
    import mgmt_sram_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [NUM_LANES-1:0] we,
    input  logic [AW-1:0]        addr,
    input  logic [DW-1:0]        din,
`ifdef MGMT_SRAM_PARITY_EN
    output logic [NUM_LANES-1:0] pout,
`endif
    output logic [DW-1:0]        dout
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Byte-lane write; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (we[l]) begin
                    mem[addr][l*LANE_W +: LANE_W] <= din[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign dout = mem[addr];

`ifdef MGMT_SRAM_PARITY_EN
    logic [NUM_LANES-1:0] pmem [DEPTH];
    logic [NUM_LANES-1:0] din_par;

    assign din_par = lane_parity(din);

    // Parity bit travels with its byte lane.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (we[l]) begin
                    pmem[addr][l] <= din_par[l];
                end
            end
        end
    end

    assign pout = pmem[addr];
`endif

endmodule

// File: rtl/mgmt_sram_ctrl.sv
// mgmt_sram_ctrl: banked management SRAM controller. Splits the SRAM into
// NUM_BANKS banks and arbitrates each bank between the CPU read/write port
// and the housekeeping (HK) read-only port. CPU wins same-bank conflicts
// until HK has lost HK_MAX_WAIT times, then HK is forced to win once.
// Reads return one cycle after grant. Build option MGMT_SRAM_PARITY_EN
// enables per-byte parity checking with a sticky par_err.
// Ports:
//   core_clk, core_rstn        - clock, async active-low reset
//   cpu_en/we/addr/di          - CPU request (held until cpu_rdy)
//   cpu_rdy                    - combinational accept
//   cpu_do, cpu_dvld           - CPU read data and one-cycle valid
//   hk_req/hk_addr             - HK read request (level, held until ack)
//   hk_ack, hk_data            - HK one-cycle ack and read data
//   par_err                    - sticky parity error (0 without parity)
module mgmt_sram_ctrl
    import mgmt_sram_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = 2,
    parameter int unsigned BANK_AW     = 8,
    parameter int unsigned HK_MAX_WAIT = 4
) (
    input  logic                                        core_clk,
    input  logic                                        core_rstn,
    input  logic                                        cpu_en,
    input  logic [3:0]                                  cpu_we,
    input  logic [BANK_AW+bank_sel_w(NUM_BANKS)-1:0]    cpu_addr,
    input  logic [31:0]                                 cpu_di,
    output logic                                        cpu_rdy,
    output logic [31:0]                                 cpu_do,
    output logic                                        cpu_dvld,
    input  logic                                        hk_req,
    input  logic [BANK_AW+bank_sel_w(NUM_BANKS)-1:0]    hk_addr,
    output logic                                        hk_ack,
    output logic [31:0]                                 hk_data,
    output logic                                        par_err
);

    localparam int unsigned SEL_W = bank_sel_w(NUM_BANKS);
    localparam int unsigned AW    = BANK_AW + SEL_W;
    localparam int unsigned IDX_W = bank_idx_w(NUM_BANKS);

    logic              live_q;
    logic [WAIT_W-1:0] hk_wait_q;
    logic [WAIT_W-1:0] hk_wait_d;
    logic [IDX_W-1:0]  cpu_bank;
    logic [IDX_W-1:0]  hk_bank;

    logic same_bank;
    logic hk_eff;
    logic hk_force;
    logic cpu_gnt;
    logic hk_gnt;
    logic cpu_rd;

    gnt_e                 gnt       [NUM_BANKS];
    logic                 bank_en   [NUM_BANKS];
    logic [NUM_LANES-1:0] bank_we   [NUM_BANKS];
    logic [BANK_AW-1:0]   bank_addr [NUM_BANKS];
    logic [DW-1:0]        bank_dout [NUM_BANKS];

    // Bank decode from the upper address bits.
    generate
        if (NUM_BANKS > 1) begin : g_dec
            assign cpu_bank = cpu_addr[AW-1:BANK_AW];
            assign hk_bank  = hk_addr[AW-1:BANK_AW];
        end else begin : g_nodec
            assign cpu_bank = '0;
            assign hk_bank  = '0;
        end
    endgenerate

    // Arbitration. The ack cycle of an HK grant is not a new request, so an
    // HK master still holding hk_req during its ack is not served twice.
    always_comb begin
        same_bank = (cpu_bank == hk_bank);
        hk_eff    = hk_req & ~hk_ack;
        hk_force  = hk_eff & (hk_wait_q == WAIT_W'(HK_MAX_WAIT));
        cpu_rdy   = live_q & ~(hk_force & same_bank);
        cpu_gnt   = cpu_en & cpu_rdy;
        hk_gnt    = live_q & hk_eff & (hk_force | ~(cpu_en & same_bank));
        cpu_rd    = cpu_gnt & (cpu_we == 4'b0000);
    end

    // HK loss counter: count same-bank losses, clear on any HK grant.
    always_comb begin
        hk_wait_d = hk_wait_q;
        if (hk_gnt) begin
            hk_wait_d = '0;
        end else if (hk_eff && cpu_gnt && same_bank &&
                     (hk_wait_q < WAIT_W'(HK_MAX_WAIT))) begin
            hk_wait_d = hk_wait_q + WAIT_W'(1);
        end
    end

    // Per-bank grant and port steering.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt[b] = GNT_NONE;
            if (cpu_gnt && (cpu_bank == IDX_W'(b))) begin
                gnt[b] = GNT_CPU;
            end else if (hk_gnt && (hk_bank == IDX_W'(b))) begin
                gnt[b] = GNT_HK;
            end
            bank_en[b]   = (gnt[b] != GNT_NONE);
            bank_we[b]   = (gnt[b] == GNT_CPU) ? cpu_we : '0;
            bank_addr[b] = (gnt[b] == GNT_HK) ? hk_addr[BANK_AW-1:0]
                                              : cpu_addr[BANK_AW-1:0];
        end
    end

`ifdef MGMT_SRAM_PARITY_EN
    logic [NUM_LANES-1:0] bank_pout [NUM_BANKS];
`endif

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            mgmt_sram_bank #(
                .AW (BANK_AW)
            ) u_bank (
                .clk  (core_clk),
                .en   (bank_en[b]),
                .we   (bank_we[b]),
                .addr (bank_addr[b]),
                .din  (cpu_di),
`ifdef MGMT_SRAM_PARITY_EN
                .pout (bank_pout[b]),
`endif
                .dout (bank_dout[b])
            );
        end
    endgenerate

    // Read-return registers; data holds between pulses.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            live_q    <= 1'b0;
            hk_wait_q <= '0;
            cpu_dvld  <= 1'b0;
            cpu_do    <= '0;
            hk_ack    <= 1'b0;
            hk_data   <= '0;
        end else begin
            live_q    <= 1'b1;
            hk_wait_q <= hk_wait_d;
            cpu_dvld  <= cpu_rd;
            hk_ack    <= hk_gnt;
            if (cpu_rd) begin
                cpu_do <= bank_dout[cpu_bank];
            end
            if (hk_gnt) begin
                hk_data <= bank_dout[hk_bank];
            end
        end
    end

`ifdef MGMT_SRAM_PARITY_EN
    logic par_err_q;
    logic cpu_perr;
    logic hk_perr;

    // Any lane whose stored parity disagrees with its data flags an error.
    always_comb begin
        cpu_perr = cpu_rd &
                   (|(lane_parity(bank_dout[cpu_bank]) ^ bank_pout[cpu_bank]));
        hk_perr  = hk_gnt &
                   (|(lane_parity(bank_dout[hk_bank]) ^ bank_pout[hk_bank]));
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            par_err_q <= 1'b0;
        end else if (cpu_perr || hk_perr) begin
            par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mgmt_sram_ctrl.sv
// tb_mgmt_sram_ctrl: table-driven bench for mgmt_sram_ctrl (NUM_BANKS=2,
// BANK_AW=8, HK_MAX_WAIT=4) with a reference memory model and scoreboard
// queues for CPU and HK read returns. MGMT_SRAM_PARITY_EN adds a parity run.
module tb_mgmt_sram_ctrl;

    localparam int unsigned AW = 9;

    logic          clk;
    logic          rst_n;
    logic          cpu_en;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_di;
    logic          cpu_rdy;
    logic [31:0]   cpu_do;
    logic          cpu_dvld;
    logic          hk_req;
    logic [AW-1:0] hk_addr;
    logic          hk_ack;
    logic [31:0]   hk_data;
    logic          par_err;

    mgmt_sram_ctrl #(
        .NUM_BANKS   (2),
        .BANK_AW     (8),
        .HK_MAX_WAIT (4)
    ) dut (
        .core_clk  (clk),
        .core_rstn (rst_n),
        .cpu_en    (cpu_en),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_di    (cpu_di),
        .cpu_rdy   (cpu_rdy),
        .cpu_do    (cpu_do),
        .cpu_dvld  (cpu_dvld),
        .hk_req    (hk_req),
        .hk_addr   (hk_addr),
        .hk_ack    (hk_ack),
        .hk_data   (hk_data),
        .par_err   (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [31:0]   di;
        logic          hreq;
        logic [AW-1:0] haddr;
        logic          exp_rdy;
        logic          exp_hk;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mm [512];
    logic [31:0] cpu_q [$];
    logic [31:0] hk_q [$];
    vec_t        t1 [$];
    vec_t        t2 [$];
    logic [31:0] cpu_e;
    logic [31:0] hk_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [3:0] we, input logic [AW-1:0] addr,
                                input logic [31:0] di, input logic hreq, input logic [AW-1:0] haddr,
                                input logic exp_rdy, input logic exp_hk);
        vec_t v;
        v.en = en; v.we = we; v.addr = addr; v.di = di;
        v.hreq = hreq; v.haddr = haddr; v.exp_rdy = exp_rdy; v.exp_hk = exp_hk;
        return v;
    endfunction

    // Drive one cycle, check the accept, and update model/scoreboard.
    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        cpu_en   = v.en;
        cpu_we   = v.we;
        cpu_addr = v.addr;
        cpu_di   = v.di;
        hk_req   = v.hreq;
        hk_addr  = v.haddr;
        #2;
        check("cpu_rdy", {31'd0, cpu_rdy}, {31'd0, v.exp_rdy});
        if (v.exp_hk) hk_q.push_back(mm[v.haddr]);
        if (v.en && v.exp_rdy) begin
            if (v.we == 4'b0000) begin
                cpu_q.push_back(mm[v.addr]);
            end else begin
                for (int l = 0; l < 4; l++) begin
                    if (v.we[l]) mm[v.addr][l*8 +: 8] = v.di[l*8 +: 8];
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_rdy"},  {31'd0, cpu_rdy},  32'd0);
        check({tag, "_cpu_dvld"}, {31'd0, cpu_dvld}, 32'd0);
        check({tag, "_cpu_do"},   cpu_do,            32'd0);
        check({tag, "_hk_ack"},   {31'd0, hk_ack},   32'd0);
        check({tag, "_hk_data"},  hk_data,           32'd0);
        check({tag, "_par_err"},  {31'd0, par_err},  32'd0);
    endtask

    // Scoreboard: compare every return pulse against the queued expectation.
    always @(negedge clk) begin
        if (cpu_dvld) begin
            if (cpu_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL cpu_dvld_extra: got pulse, expected none (t=%0t)", $time);
            end else begin
                cpu_e = cpu_q.pop_front();
                check("cpu_do", cpu_do, cpu_e);
`ifndef MGMT_SRAM_PARITY_EN
                check("par_err_tied", {31'd0, par_err}, 32'd0);
`endif
            end
        end
        if (hk_ack) begin
            if (hk_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL hk_ack_extra: got pulse, expected none (t=%0t)", $time);
            end else begin
                hk_e = hk_q.pop_front();
                check("hk_data", hk_data, hk_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cpu_en = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_di = '0;
        hk_req = 1'b0; hk_addr = '0;

        // Writes, partial-lane write, parallel banks, lone HK read.
        t1.push_back(mk(1, 4'hF, 9'h005, 32'h12345678, 0, 9'h000, 1, 0));
        t1.push_back(mk(1, 4'hF, 9'h010, 32'hDEADBEEF, 0, 9'h000, 1, 0));
        t1.push_back(mk(1, 4'h2, 9'h010, 32'h0000AA00, 0, 9'h000, 1, 0));
        t1.push_back(mk(1, 4'h0, 9'h010, 32'h0,        0, 9'h000, 1, 0));
        t1.push_back(mk(1, 4'hF, 9'h003, 32'hA5A50003, 0, 9'h000, 1, 0));
        t1.push_back(mk(1, 4'hF, 9'h103, 32'h5A5A0103, 0, 9'h000, 1, 0));
        t1.push_back(mk(1, 4'hF, 9'h020, 32'hCAFEF00D, 0, 9'h000, 1, 0));
        t1.push_back(mk(1, 4'h0, 9'h003, 32'h0,        1, 9'h103, 1, 1));
        t1.push_back(mk(0, 4'h0, 9'h000, 32'h0,        0, 9'h000, 1, 0));
        t1.push_back(mk(0, 4'h0, 9'h000, 32'h0,        1, 9'h020, 1, 1));
        t1.push_back(mk(0, 4'h0, 9'h000, 32'h0,        0, 9'h000, 1, 0));

        // Post-reset read, starvation, forced grant with CPU on other bank.
        t2.push_back(mk(1, 4'h0, 9'h005, 32'h0,        0, 9'h000, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h003, 32'h0,        1, 9'h020, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h005, 32'h0,        1, 9'h020, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h010, 32'h0,        1, 9'h020, 1, 0));
        t2.push_back(mk(1, 4'hF, 9'h021, 32'h11112222, 1, 9'h020, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h003, 32'h0,        1, 9'h020, 0, 1));
        t2.push_back(mk(1, 4'h0, 9'h003, 32'h0,        0, 9'h000, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h021, 32'h0,        0, 9'h000, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h005, 32'h0,        1, 9'h103, 1, 1));
        t2.push_back(mk(1, 4'h0, 9'h005, 32'h0,        0, 9'h000, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h003, 32'h0,        1, 9'h010, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h003, 32'h0,        1, 9'h010, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h005, 32'h0,        1, 9'h010, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h005, 32'h0,        1, 9'h010, 1, 0));
        t2.push_back(mk(1, 4'h0, 9'h103, 32'h0,        1, 9'h010, 1, 1));
        t2.push_back(mk(1, 4'h0, 9'h010, 32'h0,        0, 9'h000, 1, 0));
        t2.push_back(mk(0, 4'h0, 9'h000, 32'h0,        0, 9'h000, 1, 0));
        t2.push_back(mk(0, 4'h0, 9'h000, 32'h0,        0, 9'h000, 1, 0));

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        foreach (t1[i]) apply_vec(t1[i]);

        // Reset lands right after a read is accepted: the return is dropped.
        @(negedge clk);
        cpu_en = 1'b1; cpu_we = 4'h0; cpu_addr = 9'h005; hk_req = 1'b0;
        #2;
        check("midrd_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        cpu_en = 1'b0;
        #1;
        check_reset_outputs("midrd");
        cpu_q.delete();
        hk_q.delete();
        @(negedge clk);
        check("midrd_no_dvld", {31'd0, cpu_dvld}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);

        foreach (t2[i]) apply_vec(t2[i]);

        check("cpu_q_drained", cpu_q.size(), 32'd0);
        check("hk_q_drained",  hk_q.size(),  32'd0);

`ifdef MGMT_SRAM_PARITY_EN
        apply_vec(mk(1, 4'hF, 9'h030, 32'h0F0F0F0F, 0, 9'h000, 1, 0));
        apply_vec(mk(0, 4'h0, 9'h000, 32'h0,        0, 9'h000, 1, 0));
        check("par_clean", {31'd0, par_err}, 32'd0);
        dut.g_bank[0].u_bank.mem[8'h30] = dut.g_bank[0].u_bank.mem[8'h30] ^ 32'h1;
        mm[9'h030] = mm[9'h030] ^ 32'h1;
        apply_vec(mk(1, 4'h0, 9'h030, 32'h0, 0, 9'h000, 1, 0));
        apply_vec(mk(0, 4'h0, 9'h000, 32'h0, 0, 9'h000, 1, 0));
        check("par_err_set", {31'd0, par_err}, 32'd1);
        repeat (3) apply_vec(mk(1, 4'h0, 9'h005, 32'h0, 0, 9'h000, 1, 0));
        apply_vec(mk(0, 4'h0, 9'h000, 32'h0, 0, 9'h000, 1, 0));
        check("par_err_sticky", {31'd0, par_err}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("par_err_reset", {31'd0, par_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
